out_port_arbiter: RTL and testbench
===================================

Name: out_port_arbiter

Overview:
Downstream consumer of the router's single-entry input buffers. It watches the empty flags of NUM_IN buffers and picks one non-empty buffer per transaction by round-robin. It pulses that buffer's rd_en, captures the word the buffer registers out, and presents it on a valid/ready output link toward the next router stage or the NIC.

Parameters:
DATA_WIDTH, 64, width of one flit/packet word
NUM_IN, 4, number of input buffers served (2..8)
PTR_W, $clog2(NUM_IN), width of grant index / round-robin pointer

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_empty  input  NUM_IN  empty flag of each upstream buffer; bit i = buffer i
in_data  input  NUM_IN*DATA_WIDTH  buffer data_out words, flattened; word i = bits [i*DATA_WIDTH +: DATA_WIDTH]
in_rd_en  output  NUM_IN  one-hot read pulse to the granted buffer
out_valid  output  1  out_data holds a word awaiting transfer
out_ready  input  1  downstream can accept this cycle
out_data  output  DATA_WIDTH  registered output word
grant_idx  output  PTR_W  index of the buffer whose word is in flight or held (debug/verification)

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, in_rd_en=0, out_valid=0, out_data=0, grant_idx=0.
  - rr pointer = NUM_IN-1, so input 0 has top priority first.
- A transfer occurs on a cycle with out_valid=1 and out_ready=1.
- States:
  - IDLE:
    - If any in_empty bit is 0: choose winner w and go to RD.
    - Else stay in IDLE.
  - RD (1 cycle):
    - in_rd_en[w]=1 (combinational from state and registered w); all other bits 0.
    - rr pointer <= w; grant_idx=w.
    - Next state LOAD.
  - LOAD (1 cycle):
    - Buffer w now drives the read word (registered in the buffer on the RD edge).
    - out_data <= in_data word w; out_valid <= 1.
    - Next state HOLD.
  - HOLD:
    - out_valid=1; out_data and grant_idx stay stable.
    - If out_ready=0: stay in HOLD.
    - If out_ready=1: the transfer completes. out_valid <= 0. Choose a new winner; go to RD if one exists, else IDLE.
- Winner selection: the first index with in_empty=0, searching upward circularly from (pointer+1) mod NUM_IN.
- Latency: rd_en in cycle t; out_valid from t+2.
- Peak throughput: 1 word per 3 cycles with out_ready held high (HOLD→RD→LOAD→HOLD).
- in_rd_en is only ever asserted for a buffer whose in_empty was 0 in the selecting cycle. It is never asserted in IDLE, LOAD or HOLD.
- Single-cycle empty glitch: in_empty is sampled only at selection. A buffer that empties before RD is not possible, because the buffers drain only via this block.
- Reset mid-operation:
  - A word already read from a buffer but not transferred is discarded.
  - Outputs take their reset values on the next edge.
- All NUM_IN inputs empty while in HOLD: HOLD exits to IDLE on the transfer.
- No combinational path from out_ready to in_rd_en or out_valid; both depend only on registered state.

Decomposition:
- Shared package router_pkg:
  - DATA_WIDTH, NUM_IN defaults.
  - Arbiter state enum {IDLE, RD, LOAD, HOLD}.
  - Helper function for word slicing of the flattened bus.
- Sub-module rr_arbiter(NUM_IN):
  - Inputs: request vector (~in_empty), pointer, update strobe.
  - Outputs: winner index, any-request flag.
  - Owns the pointer register; same synchronous rst.
- The FSM and output register stay in out_port_arbiter.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> in_rd_en=0, out_valid=0, out_data=0, grant_idx=0 on every post-reset cycle until a request appears.
- Single request: buffer 2 non-empty holding 64'hA5A5_0000_0000_0002, out_ready=1 -> in_rd_en=4'b0100 at cycle t, out_valid=1 with that data at t+2, one transfer, then IDLE with no further rd_en.
- All four non-empty, out_ready=1 -> grants 0,1,2,3 in order, rd_en pulses exactly 3 cycles apart, four transfers with matching data.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid, out_data and grant_idx constant; in_rd_en=0 throughout; one transfer when out_ready rises.
- Fairness: last grant=1, then buffers 0 and 3 non-empty -> buffer 3 granted before buffer 0.
- Reset during LOAD -> next cycle out_valid=0, out_data=0, state IDLE. A subsequent request from input 0 is served first (pointer reset).

Source files
------------

// File: rtl/router_pkg.sv
// Types and helpers shared by the router output-side blocks.
// Defaults, arbiter state encoding and flattened-bus word offsets.
package router_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int NUM_IN_DEF     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_LOAD = 2'd2,
    ST_HOLD = 2'd3
  } arb_state_e;

  // LSB position of word idx inside a flattened bus of width-bit words.
  function automatic int word_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among requests, searching upward from pointer+1.
// Combinational winner; pointer moves to the committed grant on upd_i.
module rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int PTR_W  = $clog2(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req_i,
  input  logic              upd_i,
  input  logic [PTR_W-1:0]  upd_idx_i,
  output logic [PTR_W-1:0]  win_o,
  output logic              any_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] idx;

  // Pointer resets to the last input so input 0 is favoured first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PTR_W'(NUM_IN - 1);
    end else if (upd_i) begin
      ptr_q <= upd_idx_i;
    end
  end

  // Walk from the farthest candidate down so the nearest requester wins.
  always_comb begin
    win_o = '0;
    idx   = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      idx = PTR_W'((int'(ptr_q) + k) % NUM_IN);
      if (req_i[idx]) begin
        win_o = idx;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/out_port_arbiter.sv
// Drains single-entry input buffers round-robin onto one valid/ready link.
// rd_en in cycle t, out_valid from t+2; holds the word while out_ready is low.
module out_port_arbiter
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_IN     = NUM_IN_DEF,
  parameter int PTR_W      = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            in_empty,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]            in_rd_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [PTR_W-1:0]             grant_idx
);

  arb_state_e            state_q;
  logic [PTR_W-1:0]      win_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic [PTR_W-1:0]      rr_win;
  logic                  any_req;
  logic [DATA_WIDTH-1:0] in_word [NUM_IN];

  for (genvar g = 0; g < NUM_IN; g++) begin : g_word
    assign in_word[g] = in_data[word_lsb(g, DATA_WIDTH) +: DATA_WIDTH];
  end

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .PTR_W  (PTR_W)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (~in_empty),
    .upd_i     (state_q == ST_RD),
    .upd_idx_i (win_q),
    .win_o     (rr_win),
    .any_o     (any_req)
  );

  // The buffer registers its word on the RD edge, so capture happens in LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            win_q   <= rr_win;
            state_q <= ST_RD;
          end
        end
        ST_RD: begin
          state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          out_data_q  <= in_word[win_q];
          out_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (any_req) begin
              win_q   <= rr_win;
              state_q <= ST_RD;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    in_rd_en = '0;
    if (state_q == ST_RD) begin
      in_rd_en[win_q] = 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign grant_idx = win_q;

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter with a transaction-level reference model.
module tb_out_port_arbiter;

  localparam int DW = 64;
  localparam int N  = 4;
  localparam int PW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_empty;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_rd_en;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [PW-1:0]   grant_idx;

  always #5 clk = ~clk;

  // Upstream single-entry buffers: contents, full flag and registered read port.
  logic [N-1:0]  buf_full;
  logic [DW-1:0] buf_dat [N];
  logic [DW-1:0] dout    [N];
  logic [N-1:0]  rd_seen = '0;

  assign in_empty = ~buf_full;
  for (genvar g = 0; g < N; g++) begin : g_flat
    assign in_data[g*DW +: DW] = dout[g];
  end

  out_port_arbiter #(.DATA_WIDTH(DW), .NUM_IN(N), .PTR_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_empty  (in_empty),
    .in_data   (in_data),
    .in_rd_en  (in_rd_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .grant_idx (grant_idx)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a grant is chosen at an edge, read on the next cycle,
  // presented two cycles after the read, and held until accepted.
  bit            m_init = 1'b0;
  int            m_ptr;
  bit            m_valid;
  logic [63:0]   m_data;
  int            m_gidx;
  int            m_stage;
  int            m_pidx;
  logic [63:0]   m_pdat;
  bit            m_data_rst;
  bit            m_gidx_rst;

  int            rd_cyc [$];
  logic [N-1:0]  rd_vec [$];
  int            x_cyc  [$];
  int            x_idx  [$];
  logic [63:0]   x_dat  [$];

  function automatic int pick(input int ptr, input logic [N-1:0] empty);
    logic [N-1:0] t;
    for (int k = 1; k <= N; k++) begin
      t = empty >> ((ptr + k) % N);
      if (!t[0]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] exp_rd;
    bit           xfer;
    int           w;
    cyc++;
    rd_seen = in_rd_en;
    if (m_init) begin
      exp_rd = '0;
      if (m_stage == 2) exp_rd = N'(1) << m_pidx;
      chk("rd_en", 64'(in_rd_en), 64'(exp_rd));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid || m_data_rst) chk("out_data", out_data, m_data);
      if (m_valid || m_stage != 0 || m_gidx_rst) chk("grant_idx", 64'(grant_idx), 64'(m_gidx));
      if (in_rd_en != '0) begin
        rd_cyc.push_back(cyc);
        rd_vec.push_back(in_rd_en);
      end
      if (out_valid && out_ready) begin
        x_cyc.push_back(cyc);
        x_idx.push_back(int'(grant_idx));
        x_dat.push_back(out_data);
      end
    end
    if (rst) begin
      m_init = 1'b1; m_ptr = N - 1; m_valid = 1'b0; m_data = '0; m_gidx = 0;
      m_stage = 0; m_data_rst = 1'b1; m_gidx_rst = 1'b1;
    end else if (m_init) begin
      xfer = m_valid && out_ready;
      if (m_stage == 2) begin
        m_ptr = m_pidx; m_stage = 1;
      end else if (m_stage == 1) begin
        m_valid = 1'b1; m_data = m_pdat; m_stage = 0; m_data_rst = 1'b0;
      end else if (!m_valid || xfer) begin
        if (xfer) m_valid = 1'b0;
        w = pick(m_ptr, in_empty);
        if (w >= 0) begin
          m_stage = 2; m_pidx = w; m_gidx = w; m_pdat = buf_dat[w]; m_gidx_rst = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rd_seen[i]) begin
        dout[i]     = buf_dat[i];
        buf_full[i] = 1'b0;
      end
    end
  endtask

  task automatic fill(input int i, input logic [63:0] d);
    buf_full[i] = 1'b1;
    buf_dat[i]  = d;
  endtask

  task automatic wait_x(input int target, input int budget, input string name);
    int n = 0;
    while (x_cyc.size() < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(x_cyc.size()), 64'(target));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of the test sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rb, xb, n;
    rst       = 1'b1;
    out_ready = 1'b0;
    buf_full  = '0;
    for (int i = 0; i < N; i++) begin
      buf_dat[i] = {$urandom, $urandom};
      dout[i]    = {$urandom, $urandom};
    end
    repeat (2) begin
      out_ready = 1'($urandom_range(0, 1));
      buf_full  = N'($urandom);
      for (int i = 0; i < N; i++) dout[i] = {$urandom, $urandom};
      tick();
    end
    rst = 1'b0; buf_full = '0; out_ready = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_gidx", 64'(grant_idx), 64'd0);
    chk("rst_rd_en", 64'(in_rd_en), 64'd0);
    repeat (3) tick();

    // Single request on buffer 2.
    rb = rd_cyc.size(); xb = x_cyc.size();
    fill(2, 64'hA5A5_0000_0000_0002);
    wait_x(xb + 1, 20, "t1_wait");
    repeat (6) tick();
    chk("t1_rd_count", 64'(rd_cyc.size() - rb), 64'd1);
    chk("t1_rd_vec", 64'(rd_vec[rb]), 64'h4);
    chk("t1_data", x_dat[xb], 64'hA5A5_0000_0000_0002);
    chk("t1_idx", 64'(x_idx[xb]), 64'd2);
    chk("t1_latency", 64'(x_cyc[xb] - rd_cyc[rb]), 64'd2);

    // All four buffers from a fresh pointer.
    rst = 1'b1; tick(); rst = 1'b0;
    rb = rd_cyc.size(); xb = x_cyc.size();
    for (int i = 0; i < N; i++) fill(i, 64'hC0DE_0000_0000_0000 + 64'(i));
    wait_x(xb + 4, 40, "t2_wait");
    for (int k = 0; k < 4; k++) begin
      chk("t2_idx", 64'(x_idx[xb + k]), 64'(k));
      chk("t2_data", x_dat[xb + k], 64'hC0DE_0000_0000_0000 + 64'(k));
    end
    for (int k = 0; k < 3; k++) chk("t2_spacing", 64'(rd_cyc[rb + k + 1] - rd_cyc[rb + k]), 64'd3);

    // Backpressure in HOLD.
    out_ready = 1'b0; xb = x_cyc.size();
    fill(1, 64'hBEEF_0000_0000_0001);
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    chk("t3_valid_rise", 64'(out_valid), 64'd1);
    repeat (5) begin
      tick();
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_data", out_data, 64'hBEEF_0000_0000_0001);
      chk("t3_hold_gidx", 64'(grant_idx), 64'd1);
      chk("t3_no_rd", 64'(in_rd_en), 64'd0);
    end
    chk("t3_no_xfer", 64'(x_cyc.size()), 64'(xb));
    out_ready = 1'b1;
    repeat (4) tick();
    chk("t3_one_xfer", 64'(x_cyc.size()), 64'(xb + 1));

    // Fairness after a grant to 1: 3 before 0.
    xb = x_cyc.size();
    fill(0, 64'h0000_0000_0000_0F00);
    fill(3, 64'h0000_0000_0000_0F03);
    wait_x(xb + 2, 20, "t4_wait");
    chk("t4_first", 64'(x_idx[xb]), 64'd3);
    chk("t4_second", 64'(x_idx[xb + 1]), 64'd0);
    chk("t4_data", x_dat[xb], 64'h0000_0000_0000_0F03);

    // Reset while the read word is being loaded.
    rb = rd_cyc.size();
    fill(2, 64'hDEAD_0000_0000_0002);
    n = 0;
    while (rd_cyc.size() == rb && n < 10) begin tick(); n++; end
    chk("t5_rd_seen", 64'(rd_cyc.size()), 64'(rb + 1));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_data", out_data, 64'd0);
    chk("t5_gidx", 64'(grant_idx), 64'd0);
    xb = x_cyc.size();
    fill(0, 64'h0000_0000_0000_0A00);
    fill(3, 64'h0000_0000_0000_0A03);
    wait_x(xb + 2, 20, "t5_wait");
    chk("t5_first", 64'(x_idx[xb]), 64'd0);
    chk("t5_second", 64'(x_idx[xb + 1]), 64'd3);
    chk("t5_data", x_dat[xb], 64'h0000_0000_0000_0A00);

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
